// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display controller.
package disp_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; packed so entry n is SEG_LUT[n] (listed F down to 0).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return SEG_LUT[hex];
  endfunction

endpackage

// File: rtl/disp_scan_seg7_decode.sv
// Combinational hex to active-low seven-segment decoder.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed seven-segment scanner: prescaler, digit scan, PWM dimming, guard
// interval, leading-zero suppression and a frame-synchronous double buffer.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 100000,
  parameter int BRIGHT_W   = 3,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start,
  output logic                    load_pending
);

  localparam int CNT_W = idx_width(TICK_DIV);
  localparam int IDX_W = idx_width(NUM_DIGITS);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [BRIGHT_W-1:0]     pwm;
  logic [4*NUM_DIGITS-1:0] act_digits, pend_digits;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp, act_blank, pend_blank;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    tick, last_slot, apply;
  logic [3:0]              sel_digit;
  logic [6:0]              dec_seg;
  logic [BRIGHT_W-1:0]     pwm_mod;
  logic                    lz_supp, lit;

  assign tick      = (cnt == CNT_W'(TICK_DIV - 1));
  assign last_slot = (idx == IDX_W'(NUM_DIGITS - 1));
  // A same-cycle load is folded into the apply so fresh data lands directly in active.
  assign apply     = tick && last_slot && (load_pending || load);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
      pwm <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      pwm <= tick ? '0 : pwm + 1'b1;
      if (tick) idx <= last_slot ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_digits   <= '0;
      act_dp       <= '0;
      act_blank    <= '0;
      pend_digits  <= '0;
      pend_dp      <= '0;
      pend_blank   <= '0;
      load_pending <= 1'b0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_blank  <= blank_in;
      end
      if (apply) begin
        act_digits   <= load ? digits_in : pend_digits;
        act_dp       <= load ? dp_in     : pend_dp;
        act_blank    <= load ? blank_in  : pend_blank;
        load_pending <= 1'b0;
      end else if (load) begin
        load_pending <= 1'b1;
      end
    end
  end

  // lz_mask[i] is set when every active digit from the top down to i is zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (act_digits[4*i +: 4] == 4'h0);
      lz_mask[i] = all_zero;
    end
  end

  assign sel_digit = act_digits[{idx, 2'b00} +: 4];
  assign pwm_mod   = pwm - BRIGHT_W'(GUARD);
  assign lz_supp   = lz_en && lz_mask[idx];
  // A zero-suppressed digit keeps its anode only to show a lit decimal point.
  assign lit       = (cnt >= CNT_W'(GUARD)) && (pwm_mod <= bright) &&
                     !act_blank[idx] && !(lz_supp && !act_dp[idx]);

  seg7_decode u_dec (
    .hex (sel_digit),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      seg         <= (lit && !lz_supp) ? dec_seg : SEG_OFF;
      dp          <= lit ? ~act_dp[idx] : 1'b1;
      frame_start <= tick && last_slot;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with a cycle model feeding an expected queue.
module tb_disp_scan_ctrl;

  localparam int N  = 4;
  localparam int TD = 8;
  localparam int BW = 2;
  localparam int GD = 2;
  localparam int W  = 18;  // {idx[1:0], cnt[2:0], an[3:0], seg[6:0], dp, frame_start}

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0]  dp_in = '0;
  logic [N-1:0]  blank_in = '0;
  logic          lz_en = 1'b0;
  logic          load = 1'b0;
  logic [BW-1:0] bright = 2'd3;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_start;
  logic          load_pending;

  disp_scan_ctrl #(
    .NUM_DIGITS (N),
    .TICK_DIV   (TD),
    .BRIGHT_W   (BW),
    .GUARD      (GD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .digits_in    (digits_in),
    .dp_in        (dp_in),
    .blank_in     (blank_in),
    .lz_en        (lz_en),
    .load         (load),
    .bright       (bright),
    .an           (an),
    .seg          (seg),
    .dp           (dp),
    .frame_start  (frame_start),
    .load_pending (load_pending)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [W-1:0]   exp_q[$];
  int             m_cnt, m_idx;
  logic [4*N-1:0] m_act_d, m_pend_d;
  logic [N-1:0]   m_act_p, m_pend_p, m_act_b, m_pend_b;
  logic           m_lp;
  int             shown_idx, shown_cnt;
  logic           shown_valid = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [3:0]   e_an;
    logic [6:0]   e_seg;
    logic         e_dp, all_zero, supp, win, tick, apply;
    if (!rst) begin
      exp_q.delete();
      m_cnt = 0; m_idx = 0; m_lp = 1'b0;
      m_act_d = '0; m_act_p = '0; m_act_b = '0;
      m_pend_d = '0; m_pend_p = '0; m_pend_b = '0;
      shown_valid = 1'b0;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        shown_idx   = int'(e[17:16]);
        shown_cnt   = int'(e[15:13]);
        shown_valid = 1'b1;
        check("pins", {19'd0, an, seg, dp, frame_start}, {19'd0, e[12:0]});
      end
      check("load_pending", {31'd0, load_pending}, {31'd0, m_lp});

      all_zero = 1'b1;
      for (int j = N - 1; j >= m_idx; j--)
        if (m_act_d[4*j +: 4] != 4'h0) all_zero = 1'b0;
      supp  = lz_en && (m_idx != 0) && all_zero;
      win   = (m_cnt >= GD) && (((m_cnt - GD) & 3) <= int'(bright));
      e_an  = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if (win && !m_act_b[m_idx] && (!supp || m_act_p[m_idx])) begin
        e_an  = ~(4'b0001 << m_idx);
        e_seg = supp ? 7'h7F : lut[m_act_d[4*m_idx +: 4]];
        e_dp  = ~m_act_p[m_idx];
      end
      exp_q.push_back({m_idx[1:0], m_cnt[2:0], e_an, e_seg, e_dp,
                       (m_cnt == TD - 1) && (m_idx == N - 1)});

      tick  = (m_cnt == TD - 1);
      apply = tick && (m_idx == N - 1) && (m_lp || load);
      if (apply && load) begin
        m_act_d = digits_in; m_act_p = dp_in; m_act_b = blank_in;
        m_pend_d = digits_in; m_pend_p = dp_in; m_pend_b = blank_in;
        m_lp = 1'b0;
      end else if (apply) begin
        m_act_d = m_pend_d; m_act_p = m_pend_p; m_act_b = m_pend_b;
        m_lp = 1'b0;
      end else if (load) begin
        m_pend_d = digits_in; m_pend_p = dp_in; m_pend_b = blank_in;
        m_lp = 1'b1;
      end
      if (tick) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % N;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    @(posedge clk); #1;
    digits_in = d; dp_in = p; blank_in = b; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Waits until the pins reflect model state (i, c); checks are made at negedge+1.
  task automatic wait_shown(input int i, input int c);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(shown_valid && shown_idx == i && shown_cnt == c) && n < 300);
    if (n >= 300) check("wait_shown_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (frame_start !== 1'b1 && n < 300);
    if (n >= 300) check("wait_frame_timeout", 32'd0, 32'd1);
  endtask

  // Called right after reset release at posedge+1; counts negedges until frame_start.
  task automatic first_frame_latency();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 100);
    check("first_frame_latency", n, 33);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dp", {31'd0, dp}, 32'd1);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_load_pending", {31'd0, load_pending}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    first_frame_latency();

    // Basic display at full brightness
    do_load(16'h12A0, 4'b0000, 4'b0000);
    wait_frame();
    wait_shown(0, 4); check("s0_an", {28'd0, an}, 32'hE); check("s0_seg", {25'd0, seg}, 32'h40);
    wait_shown(0, 1); check("s0_guard_an", {28'd0, an}, 32'hF);
    wait_shown(1, 3); check("s1_an", {28'd0, an}, 32'hD); check("s1_seg", {25'd0, seg}, 32'h08);

    // Minimum brightness: lit only where (cnt-2) mod 4 == 0
    @(posedge clk); #1; bright = 2'd0;
    wait_frame();
    wait_shown(0, 2); check("dim_cnt2_an", {28'd0, an}, 32'hE);
    wait_shown(0, 3); check("dim_cnt3_an", {28'd0, an}, 32'hF);
    wait_shown(0, 6); check("dim_cnt6_an", {28'd0, an}, 32'hE);
    @(posedge clk); #1; bright = 2'(1 + $urandom_range(0, 1));
    repeat (2) wait_frame();
    @(posedge clk); #1; bright = 2'd3;

    // Leading-zero suppression
    @(posedge clk); #1; lz_en = 1'b1;
    do_load(16'h0005, 4'b0000, 4'b0000);
    wait_frame();
    wait_shown(0, 4); check("lz_d0_seg", {25'd0, seg}, 32'h12);
    wait_shown(1, 4); check("lz_d1_an", {28'd0, an}, 32'hF);
    wait_shown(3, 4); check("lz_d3_an", {28'd0, an}, 32'hF);
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_frame();
    wait_shown(0, 4); check("lz_zero_d0_seg", {25'd0, seg}, 32'h40);
    @(posedge clk); #1; lz_en = 1'b0;

    // Double buffer: loads mid-frame, latest wins, applied at the frame boundary
    wait_frame();
    wait_shown(1, 2);
    do_load(16'h3456, 4'b0000, 4'b0000);
    check("lp_set", {31'd0, load_pending}, 32'd1);
    wait_shown(1, 5); check("old_d1_seg", {25'd0, seg}, 32'h40);
    wait_shown(2, 2);
    do_load(16'h789B, 4'b0000, 4'b0000);
    wait_shown(3, 4); check("old_d3_seg", {25'd0, seg}, 32'h40);
    check("lp_held", {31'd0, load_pending}, 32'd1);
    wait_frame();
    check("lp_clear", {31'd0, load_pending}, 32'd0);
    wait_shown(0, 4); check("new_d0_seg", {25'd0, seg}, 32'h03);
    wait_shown(1, 4); check("new_d1_seg", {25'd0, seg}, 32'h10);

    // Load landing on the apply tick itself
    wait_shown(3, 5);
    do_load(16'hF0E1, 4'b0000, 4'b0000);
    wait_shown(0, 4); check("same_cycle_d0_seg", {25'd0, seg}, 32'h79);

    // Decimal point and blanking, then asynchronous reset mid-slot
    do_load(16'h4321, 4'b0100, 4'b0010);
    wait_frame();
    wait_shown(2, 4); check("dp_d2", {31'd0, dp}, 32'd0); check("d2_seg", {25'd0, seg}, 32'h30);
    wait_shown(3, 4); check("dp_d3", {31'd0, dp}, 32'd1); check("d3_seg", {25'd0, seg}, 32'h19);
    wait_frame();
    wait_shown(1, 4); check("blank_d1_an", {28'd0, an}, 32'hF);
    wait_shown(2, 4); check("pre_rst_an", {28'd0, an}, 32'hB);
    #2 rst = 1'b0;
    #1;
    check("async_an", {28'd0, an}, 32'hF);
    check("async_seg", {25'd0, seg}, 32'h7F);
    check("async_dp", {31'd0, dp}, 32'd1);
    check("async_lp", {31'd0, load_pending}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    first_frame_latency();
    wait_shown(0, 4); check("post_rst_seg", {25'd0, seg}, 32'h40);
    check("post_rst_dp", {31'd0, dp}, 32'd1);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
